// File: rtl/ram_port_arbiter_pkg.sv
// Shared types and default widths for the RAM port arbiter slice.
package ram_arb_pkg;

    localparam int DEF_ADDR_W = 12;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_BE_W   = DEF_DATA_W / 8;

    typedef logic req_idx_t;

    typedef struct packed {
        logic [DEF_ADDR_W-1:0] address;
        logic [DEF_BE_W-1:0]   byteenable;
        logic                  write;
        logic [DEF_DATA_W-1:0] writedata;
    } ram_req_t;

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Avalon-MM requester bundle between one master and the RAM arbiter.
interface ram_port_arbiter_if
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);

    logic [ADDR_W-1:0]   address;
    logic [DATA_W/8-1:0] byteenable;
    logic                read;
    logic                write;
    logic [DATA_W-1:0]   writedata;
    logic                waitrequest;
    logic [DATA_W-1:0]   readdata;
    logic                readdatavalid;

    modport master (
        output address, byteenable, read, write, writedata,
        input  waitrequest, readdata, readdatavalid
    );

    modport slave (
        input  address, byteenable, read, write, writedata,
        output waitrequest, readdata, readdatavalid
    );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-input round-robin grant with last-grant register and requester-0 lock.
module rr_arbiter2
    import ram_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       lock,
    output logic [1:0] gnt,
    output req_idx_t   gnt_idx
);

    logic last_gnt;
    logic lock_d;
    logic own_q;
    logic lock_act;

    assign lock_act = lock & own_q;
    assign gnt_idx  = gnt[1];

    always_comb begin
        gnt = 2'b00;
        unique case (1'b1)
            lock_act:
                gnt = {1'b0, req[0]};
            (~lock_act & (&req)):
                gnt = last_gnt ? 2'b01 : 2'b10;
            default:
                gnt = req;
        endcase
    end

    // Lock only takes hold if requester 0 wins the cycle the lock rises.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_gnt <= 1'b1;
            lock_d   <= 1'b0;
            own_q    <= 1'b0;
        end else begin
            if (|gnt)
                last_gnt <= gnt[1];
            lock_d <= lock;
            own_q  <= lock & (own_q | (~lock_d & gnt[0]));
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one single-port RAM between two Avalon-MM requesters, round-robin.
// Define RAM_ARB_LOCK_EN to add m0_lock for atomic requester-0 sequences.
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                clk,
    input  logic                reset_n,
    ram_port_arbiter_if.slave   m0,
    ram_port_arbiter_if.slave   m1,
`ifdef RAM_ARB_LOCK_EN
    input  logic                m0_lock,
`endif
    output logic [ADDR_W-1:0]   ram_address,
    output logic [DATA_W/8-1:0] ram_byteenable,
    output logic                ram_chipselect,
    output logic                ram_write,
    output logic [DATA_W-1:0]   ram_writedata,
    input  logic [DATA_W-1:0]   ram_readdata
);

    logic [1:0] req;
    logic [1:0] gnt;
    req_idx_t   gnt_idx;
    logic       issue;
    logic       lock;
    ram_req_t   r0;
    ram_req_t   r1;
    ram_req_t   sel;
    logic       rd_pend;
    req_idx_t   rd_owner;

`ifdef RAM_ARB_LOCK_EN
    assign lock = m0_lock;
`else
    assign lock = 1'b0;
`endif

    assign req = {m1.read | m1.write, m0.read | m0.write};

    rr_arbiter2 u_arb (
        .clk     (clk),
        .rst_n   (reset_n),
        .req     (req),
        .lock    (lock),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign issue = |gnt;

    always_comb begin
        r0.address    = m0.address;
        r0.byteenable = m0.byteenable;
        r0.write      = m0.write;
        r0.writedata  = m0.writedata;
        r1.address    = m1.address;
        r1.byteenable = m1.byteenable;
        r1.write      = m1.write;
        r1.writedata  = m1.writedata;
    end

    assign sel = gnt_idx ? r1 : r0;

    assign ram_address    = sel.address;
    assign ram_byteenable = sel.write ? sel.byteenable : '1;
    assign ram_chipselect = issue;
    assign ram_write      = issue & sel.write;
    assign ram_writedata  = sel.writedata;

    assign m0.waitrequest = req[0] & ~gnt[0];
    assign m1.waitrequest = req[1] & ~gnt[1];

    // RAM q appears the cycle after the address edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_pend  <= 1'b0;
            rd_owner <= 1'b0;
        end else begin
            rd_pend <= issue & ~sel.write;
            if (issue)
                rd_owner <= gnt_idx;
        end
    end

    assign m0.readdatavalid = rd_pend & (rd_owner == 1'b0);
    assign m1.readdatavalid = rd_pend & (rd_owner == 1'b1);
    assign m0.readdata      = ram_readdata;
    assign m1.readdata      = ram_readdata;

endmodule
